// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - dmem-window peripheral: key FIFO, prescaled timer with compare IRQ, LED register
module mmio_responder #(
    parameter logic [11:0] BASE_ADDR  = 12'hF00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          PRESCALE   = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q,
    output logic        hit,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic        irq,
    output logic [15:0] led
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0]   PRE_MAX = 32'(PRESCALE - 1);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [11:0] r_prev_addr;
    logic        r_prev_wren, r_prev_vld;
    logic        r_ovf, r_match;
    logic [31:0] r_timer, r_cmp, r_presc;
    logic [2:0]  r_ctrl;
    logic [15:0] r_led;
    logic [31:0] r_q;
    logic        r_hit, r_irq;

    logic        w_in_win;
    logic [2:0]  w_off;
    logic [AW:0] w_count;
    logic        w_empty, w_full;
    logic [7:0]  w_head;
    logic        w_fresh, w_kd_fresh, w_pop, w_push, w_ovf_set;
    logic        w_wr_status, w_wr_timer, w_wr_cmp, w_wr_ctrl, w_wr_led;
    logic        w_tick, w_match_set;
    logic [31:0] w_timer_inc, w_status, w_rdata;

    assign w_in_win = (address[11:3] == BASE_ADDR[11:3]);
    assign w_off    = address[2:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == DEPTH_C);
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    // A held load must pop only once: qualify on a change of address or a preceding store.
    assign w_fresh    = !r_prev_vld || (r_prev_addr != address) || r_prev_wren;
    assign w_kd_fresh = w_in_win && (w_off == 3'd1) && !wren && w_fresh;
    assign w_pop      = w_kd_fresh && !w_empty;
    assign w_push     = key_valid && (!w_full || w_pop);
    assign w_ovf_set  = key_valid && w_full && !w_pop;

    assign w_wr_status = w_in_win && wren && (w_off == 3'd0);
    assign w_wr_timer  = w_in_win && wren && (w_off == 3'd2);
    assign w_wr_cmp    = w_in_win && wren && (w_off == 3'd3);
    assign w_wr_ctrl   = w_in_win && wren && (w_off == 3'd4);
    assign w_wr_led    = w_in_win && wren && (w_off == 3'd5);

    assign w_tick      = r_ctrl[0] && (r_presc == PRE_MAX);
    assign w_timer_inc = r_timer + 32'd1;
    assign w_match_set = w_tick && !w_wr_timer && (w_timer_inc == r_cmp);

    always_comb begin
        w_status        = '0;
        w_status[AW:0]  = w_count;
        w_status[16]    = w_empty;
        w_status[17]    = w_full;
        w_status[18]    = r_ovf;
        w_status[19]    = r_match;
    end

    always_comb begin
        w_rdata = '0;
        if (w_in_win) begin
            case (w_off)
                3'd0:    w_rdata = w_status;
                3'd1:    w_rdata = w_kd_fresh ? (w_empty ? 32'd0 : {1'b1, 23'd0, w_head}) : r_q;
                3'd2:    w_rdata = r_timer;
                3'd3:    w_rdata = r_cmp;
                3'd4:    w_rdata = {29'd0, r_ctrl};
                3'd5:    w_rdata = {16'd0, r_led};
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= key_code;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_prev_addr <= '0;
            r_prev_wren <= 1'b0;
            r_prev_vld  <= 1'b0;
            r_ovf       <= 1'b0;
            r_match     <= 1'b0;
            r_timer     <= '0;
            r_cmp       <= '0;
            r_presc     <= '0;
            r_ctrl      <= '0;
            r_led       <= '0;
            r_q         <= '0;
            r_hit       <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_prev_addr <= address;
            r_prev_wren <= wren;
            r_prev_vld  <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            // Sticky sets win over a same-cycle W1C.
            r_ovf   <= w_ovf_set   | (r_ovf   & ~(w_wr_status & data[18]));
            r_match <= w_match_set | (r_match & ~(w_wr_status & data[19]));
            if (w_wr_timer) begin
                r_timer <= data;
                r_presc <= '0;
            end else if (r_ctrl[0]) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_timer <= w_timer_inc;
                end else begin
                    r_presc <= r_presc + 32'd1;
                end
            end
            if (w_wr_cmp)  r_cmp  <= data;
            if (w_wr_ctrl) r_ctrl <= data[2:0];
            if (w_wr_led)  r_led  <= data[15:0];
            r_q   <= w_rdata;
            r_hit <= w_in_win;
            r_irq <= (r_match & r_ctrl[1]) | (!w_empty & r_ctrl[2]);
        end
    end

    assign q   = r_q;
    assign hit = r_hit;
    assign irq = r_irq;
    assign led = r_led;
endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - vector table, directed corner sequences and random run against a queue-based model
module tb_mmio_responder;
    localparam logic [11:0] BASE  = 12'hF00;
    localparam int          DEPTH = 8;
    localparam int          PRE   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q;
    logic        hit;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = '0;
    logic        irq;
    logic [15:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PRESCALE(PRE)) dut (
        .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren),
        .q(q), .hit(hit), .key_valid(key_valid), .key_code(key_code), .irq(irq), .led(led)
    );

    always #5 clock = ~clock;

    logic [7:0]  m_fifo[$];
    logic        m_ovf, m_match, m_pv, m_pwren, m_hit, m_irq;
    logic [31:0] m_timer, m_cmp, m_q;
    logic [2:0]  m_ctrl;
    logic [15:0] m_led;
    logic [11:0] m_paddr;
    int          m_presc;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        wren;
        logic [31:0] exp_q;
        logic        exp_hit;
        logic [15:0] exp_led;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf = 0; m_match = 0; m_pv = 0; m_pwren = 0; m_hit = 0; m_irq = 0;
        m_timer = 0; m_cmp = 0; m_q = 0; m_ctrl = 0; m_led = 0; m_paddr = 0; m_presc = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("reset_outputs", {q[15:0], led, 13'd0, hit, irq, 1'b0} | {16'd0, q[31:16]}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w,
                        input logic kv, input logic [7:0] kc);
        logic        in_win, fresh, emp, ful, pop, tick, ovf_set, match_set, eirq, wr, w1c18, w1c19;
        logic [2:0]  off;
        logic [31:0] st, eq, t1;
        int          sz;
        address = a; data = d; wren = w; key_valid = kv; key_code = kc;
        in_win = (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 8);
        off    = 3'(int'(a) - int'(BASE));
        sz     = m_fifo.size();
        emp    = (sz == 0);
        ful    = (sz == DEPTH);
        fresh  = !m_pv || (m_paddr != a) || m_pwren;
        st     = 32'(sz) | (32'(emp) << 16) | (32'(ful) << 17) | (32'(m_ovf) << 18) | (32'(m_match) << 19);
        eq = 0;
        if (in_win) begin
            case (off)
                0: eq = st;
                1: eq = (!w && fresh) ? (emp ? 32'd0 : (32'h8000_0000 + 32'(m_fifo[0]))) : m_q;
                2: eq = m_timer;
                3: eq = m_cmp;
                4: eq = 32'(m_ctrl);
                5: eq = 32'(m_led);
                default: eq = 0;
            endcase
        end
        pop  = in_win && off == 1 && !w && fresh && !emp;
        eirq = (m_match && m_ctrl[1]) || (!emp && m_ctrl[2]);
        wr   = in_win && w;
        tick = m_ctrl[0] && (m_presc == PRE - 1);
        t1   = m_timer + 1;
        match_set = tick && !(wr && off == 2) && (t1 == m_cmp);
        ovf_set = 0;
        if (pop) void'(m_fifo.pop_front());
        if (kv) begin
            if (!ful || pop) m_fifo.push_back(kc);
            else ovf_set = 1;
        end
        w1c18 = wr && off == 0 && d[18];
        w1c19 = wr && off == 0 && d[19];
        m_ovf   = ovf_set   || (m_ovf   && !w1c18);
        m_match = match_set || (m_match && !w1c19);
        if (wr && off == 2) begin
            m_timer = d; m_presc = 0;
        end else if (m_ctrl[0]) begin
            if (tick) begin m_presc = 0; m_timer = t1; end
            else m_presc = m_presc + 1;
        end
        if (wr && off == 3) m_cmp = d;
        if (wr && off == 4) m_ctrl = d[2:0];
        if (wr && off == 5) m_led = d[15:0];
        m_paddr = a; m_pwren = w; m_pv = 1;
        m_q = eq; m_hit = in_win; m_irq = eirq;
        @(posedge clock);
        #1;
        n_checks++;
        if (q !== m_q || hit !== m_hit || irq !== m_irq || led !== m_led) begin
            n_fail++;
            $display("FAIL model addr=%03h wren=%0b: got q=%08h hit=%0b irq=%0b led=%04h expected q=%08h hit=%0b irq=%0b led=%04h",
                     a, w, q, hit, irq, led, m_q, m_hit, m_irq, m_led);
        end
    endtask

    task automatic rd(input logic [11:0] a);
        step(a, 32'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        step(a, d, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic push(input logic [7:0] c);
        step(12'h000, 32'd0, 1'b0, 1'b1, c);
    endtask

    initial begin
        logic [11:0] last_a;
        logic [11:0] a;
        logic [31:0] d;
        int          r;

        vecs[0]  = '{12'hF05, 32'h0000ABCD, 1'b1, 32'h0,        1'b1, 16'hABCD};
        vecs[1]  = '{12'hF05, 32'h0,        1'b0, 32'h0000ABCD, 1'b1, 16'hABCD};
        vecs[2]  = '{12'hEFF, 32'h0,        1'b0, 32'h0,        1'b0, 16'hABCD};
        vecs[3]  = '{12'hF08, 32'h0,        1'b0, 32'h0,        1'b0, 16'hABCD};
        vecs[4]  = '{12'hF04, 32'hFFFFFFF8, 1'b1, 32'h0,        1'b1, 16'hABCD};
        vecs[5]  = '{12'hF04, 32'h0,        1'b0, 32'h0,        1'b1, 16'hABCD};
        vecs[6]  = '{12'hF03, 32'h12345678, 1'b1, 32'h0,        1'b1, 16'hABCD};
        vecs[7]  = '{12'hF03, 32'h0,        1'b0, 32'h12345678, 1'b1, 16'hABCD};
        vecs[8]  = '{12'hF06, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 16'hABCD};
        vecs[9]  = '{12'hF07, 32'h0,        1'b0, 32'h0,        1'b1, 16'hABCD};
        vecs[10] = '{12'hF00, 32'h0,        1'b0, 32'h00010000, 1'b1, 16'hABCD};
        vecs[11] = '{12'hF01, 32'h0,        1'b0, 32'h0,        1'b1, 16'hABCD};
        vecs[12] = '{12'hF02, 32'h0000DEAD, 1'b1, 32'h0,        1'b1, 16'hABCD};
        vecs[13] = '{12'hF02, 32'h0,        1'b0, 32'h0000DEAD, 1'b1, 16'hABCD};

        #3;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].addr, vecs[i].data, vecs[i].wren, 1'b0, 8'd0);
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
        end

        // Push three codes, then a held read pops exactly once.
        do_reset();
        push(8'h1C); push(8'h32); push(8'h21);
        rd(BASE); check("count3", q, 32'h3);
        rd(BASE + 1); check("pop_first", q, 32'h8000001C);
        rd(BASE + 1); rd(BASE + 1); rd(BASE + 1);
        check("pop_held", q, 32'h8000001C);
        rd(BASE); check("count2", q, 32'h2);

        // Overflow, then simultaneous pop and push on a full FIFO.
        do_reset();
        for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
        rd(BASE); check("full_status", q, 32'h00060008);
        step(BASE + 1, 32'd0, 1'b0, 1'b1, 8'h77); check("full_pop", q, 32'h80000040);
        rd(BASE); check("full_kept", q, 32'h00060008);
        for (int i = 0; i < 8; i++) begin
            rd(BASE + 1);
            rd(BASE);
        end
        rd(BASE + 1); rd(BASE + 2);
        wr(BASE, 32'h00040000);
        rd(BASE); check("drained", q, 32'h00010000);

        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        step(BASE + 1, 32'd0, 1'b0, 1'b1, 8'h77);
        for (int i = 0; i < 7; i++) begin rd(BASE); rd(BASE + 1); end
        rd(BASE);
        rd(BASE + 1); check("tail_code", q, 32'h80000077);

        // Empty read.
        rd(BASE);
        rd(BASE + 1); check("empty_q", q, 32'h0); check("empty_hit", 32'(hit), 32'h1);
        rd(BASE); check("empty_count", q, 32'h00010000);

        // Timer with compare interrupt.
        do_reset();
        wr(BASE + 3, 32'd3);
        wr(BASE + 4, 32'd3);
        repeat (12) rd(12'h000);
        check("irq_before", 32'(irq), 32'h0);
        rd(BASE + 2); check("timer3", q, 32'h3); check("irq_match", 32'(irq), 32'h1);
        rd(BASE); check("match_status", q, 32'h00090000);
        wr(BASE, 32'h00080000);
        rd(12'h000); check("irq_cleared", 32'(irq), 32'h0);

        // W1C racing a match: the set wins.
        do_reset();
        wr(BASE + 3, 32'd1);
        wr(BASE + 4, 32'd1);
        repeat (3) rd(12'h000);
        wr(BASE, 32'h00080000);
        rd(BASE); check("w1c_race", q, 32'h00090000);

        // Asynchronous reset mid-operation.
        do_reset();
        push(8'h11); push(8'h22);
        wr(BASE + 5, 32'h5A5A);
        wr(BASE + 4, 32'd5);
        rd(12'h000);
        rd(BASE + 5);
        check("pre_rst_irq", 32'(irq), 32'h1);
        check("pre_rst_q", q, 32'h5A5A);
        #2;
        reset = 1'b0;
        #1;
        check("async_q", q, 32'h0);
        check("async_misc", {15'd0, hit, irq, led}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        rd(BASE); check("post_rst_status", q, 32'h00010000);

        // Randomized traffic against the model.
        last_a = BASE;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      a = last_a;
            else if (r < 8) a = BASE + 12'($urandom_range(0, 7));
            else            a = 12'($urandom);
            d = $urandom;
            if ($urandom_range(0, 7) == 0) d = m_cmp - 32'd1;
            step(a, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
            last_a = a;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
